// File: rtl/dcpu16_marb.sv
// rtl/dcpu16_marb.sv - DCPU16 F/G/X bus arbiter onto a single Wishbone-style memory port.
// The X port, its wait counter and the starvation override are built only with DCPU16_MARB_XPORT_EN.
module dcpu16_marb #(
    parameter int XWAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] f_adr,
    input  logic [15:0] f_dto,
    input  logic        f_stb,
    input  logic        f_wre,
    output logic [15:0] f_dti,
    output logic        f_ack,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    input  logic        g_wre,
    output logic [15:0] g_dti,
    output logic        g_ack,
    input  logic [15:0] x_adr,
    input  logic [15:0] x_dto,
    input  logic        x_stb,
    input  logic        x_wre,
    output logic [15:0] x_dti,
    output logic        x_ack,
    output logic [15:0] m_adr,
    output logic [15:0] m_dto,
    output logic        m_stb,
    output logic        m_wre,
    input  logic [15:0] m_dti,
    input  logic        m_ack,
    output logic [1:0]  gnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_F    = 2'd1;
    localparam logic [1:0] GNT_G    = 2'd2;
    localparam logic [1:0] GNT_X    = 2'd3;

    state_t      state;
    logic        done_f, done_g;
    logic [15:0] held_f, held_g;
    logic        live_f, live_g;
    logic        elig_f, elig_g, elig_x, force_x, any_elig;
    logic [1:0]  win;
    logic [15:0] win_adr, win_dto;
    logic        win_wre;

    assign elig_f   = f_stb && !done_f;
    assign elig_g   = g_stb && !done_g;
    assign any_elig = elig_f || elig_g || elig_x;

    // gnt is only non-zero while BUSY, so an m_ack seen in IDLE never completes anything
    assign live_f = (gnt == GNT_F) && m_ack;
    assign live_g = (gnt == GNT_G) && m_ack;

    assign f_ack = f_stb && (done_f || live_f);
    assign g_ack = g_stb && (done_g || live_g);
    assign f_dti = live_f ? m_dti : held_f;
    assign g_dti = live_g ? m_dti : held_g;

`ifdef DCPU16_MARB_XPORT_EN
    logic [3:0] xcnt;
    logic       live_x;

    assign elig_x  = x_stb;
    assign force_x = x_stb && (xcnt == 4'(XWAIT));
    assign live_x  = (gnt == GNT_X) && m_ack;
    assign x_ack   = live_x;
    assign x_dti   = live_x ? m_dti : 16'h0000;

    // Counts F/G grants that X sat through; X forces its way in once this reaches XWAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xcnt <= 4'd0;
        end else if (!x_stb) begin
            xcnt <= 4'd0;
        end else if (state == IDLE && any_elig) begin
            if (win == GNT_X) begin
                xcnt <= 4'd0;
            end else if (xcnt < 4'(XWAIT)) begin
                xcnt <= xcnt + 4'd1;
            end
        end
    end
`else
    logic unused_x;

    assign elig_x   = 1'b0;
    assign force_x  = 1'b0;
    assign x_ack    = 1'b0;
    assign x_dti    = 16'h0000;
    assign unused_x = ^{x_adr, x_dto, x_stb, x_wre, 4'(XWAIT)};
`endif

    always_comb begin
        win     = GNT_NONE;
        win_adr = f_adr;
        win_dto = f_dto;
        win_wre = f_wre;
        if (force_x) begin
            win = GNT_X;
        end else if (elig_f) begin
            win = GNT_F;
        end else if (elig_g) begin
            win = GNT_G;
        end else if (elig_x) begin
            win = GNT_X;
        end
        case (win)
            GNT_G: begin
                win_adr = g_adr;
                win_dto = 16'h0000;
                win_wre = g_wre;
            end
            GNT_X: begin
                win_adr = x_adr;
                win_dto = x_dto;
                win_wre = x_wre;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= GNT_NONE;
            m_adr <= 16'h0000;
            m_dto <= 16'h0000;
            m_wre <= 1'b0;
            m_stb <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state <= BUSY;
                        gnt   <= win;
                        m_adr <= win_adr;
                        m_dto <= win_dto;
                        m_wre <= win_wre;
                        m_stb <= 1'b1;
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        state <= IDLE;
                        gnt   <= GNT_NONE;
                        m_stb <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion landing on the same edge as ena belongs to the step being retired, so it is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_f <= 1'b0;
            done_g <= 1'b0;
            held_f <= 16'h0000;
            held_g <= 16'h0000;
        end else begin
            if (live_f) begin
                held_f <= m_dti;
            end
            if (live_g) begin
                held_g <= m_dti;
            end
            if (ena || !f_stb) begin
                done_f <= 1'b0;
            end else if (live_f) begin
                done_f <= 1'b1;
            end
            if (ena || !g_stb) begin
                done_g <= 1'b0;
            end else if (live_g) begin
                done_g <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcpu16_marb.sv
// tb/tb_dcpu16_marb.sv - self-checking bench for dcpu16_marb; X-port scenarios follow DCPU16_MARB_XPORT_EN.
module tb_dcpu16_marb;

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [15:0] f_adr, f_dto, g_adr, x_adr, x_dto;
    logic        f_stb, f_wre, g_stb, g_wre, x_stb, x_wre;
    logic [15:0] f_dti, g_dti, x_dti, m_adr, m_dto, m_dti;
    logic        f_ack, g_ack, x_ack, m_stb, m_wre, m_ack;
    logic [1:0]  gnt;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    int          wait_states, wcnt;
    logic        ack_q, ack_force;
    logic [15:0] rdata;

    always #5 clk = ~clk;

    dcpu16_marb #(.XWAIT(4)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .f_adr(f_adr), .f_dto(f_dto), .f_stb(f_stb), .f_wre(f_wre), .f_dti(f_dti), .f_ack(f_ack),
        .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dti(g_dti), .g_ack(g_ack),
        .x_adr(x_adr), .x_dto(x_dto), .x_stb(x_stb), .x_wre(x_wre), .x_dti(x_dti), .x_ack(x_ack),
        .m_adr(m_adr), .m_dto(m_dto), .m_stb(m_stb), .m_wre(m_wre), .m_dti(m_dti), .m_ack(m_ack),
        .gnt(gnt)
    );

    assign m_ack = ack_q | ack_force;
    assign m_dti = rdata;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Memory with programmable wait states; ack is a one-cycle pulse
    always @(negedge clk) begin
        if (m_stb && !ack_q) begin
            if (wcnt >= wait_states) begin
                ack_q = 1'b1;
                rdata = mem[m_adr[7:0]];
                if (m_wre) mem[m_adr[7:0]] = m_dto;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            ack_q = 1'b0;
            wcnt  = 0;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        vectors++; if (m_stb !== 1'b0) begin errors++; $display("FAIL reset_m_stb got %b want 0", m_stb); end
        vectors++; if (m_wre !== 1'b0) begin errors++; $display("FAIL reset_m_wre got %b want 0", m_wre); end
        vectors++; if (gnt !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d want 0", gnt); end
        vectors++; if ({m_adr, m_dto} !== 32'h0) begin errors++; $display("FAIL reset_m_adr_dto got %h want 0", {m_adr, m_dto}); end
        vectors++; if ({f_ack, g_ack, x_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b want 000", {f_ack, g_ack, x_ack}); end
        vectors++; if ({f_dti, g_dti, x_dti} !== 48'h0) begin errors++; $display("FAIL reset_dti got %h want 0", {f_dti, g_dti, x_dti}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_write_latency();
        wait_states = 0;
        f_adr = 16'h0010; f_dto = 16'hBEEF; f_wre = 1'b1; f_stb = 1'b1;
        cyc();
        vectors++; if (m_stb !== 1'b1) begin errors++; $display("FAIL lat_m_stb got %b want 1", m_stb); end
        vectors++; if (m_adr !== 16'h0010) begin errors++; $display("FAIL lat_m_adr got %h want 0010", m_adr); end
        vectors++; if (m_wre !== 1'b1) begin errors++; $display("FAIL lat_m_wre got %b want 1", m_wre); end
        vectors++; if (m_dto !== 16'hBEEF) begin errors++; $display("FAIL lat_m_dto got %h want beef", m_dto); end
        vectors++; if (gnt !== 2'd1) begin errors++; $display("FAIL lat_gnt got %0d want 1", gnt); end
        vectors++; if (f_ack !== 1'b1) begin errors++; $display("FAIL lat_f_ack got %b want 1", f_ack); end
        cyc();
        vectors++; if ({f_ack, m_stb} !== 2'b10) begin errors++; $display("FAIL lat_hold got ack,stb=%b want 10", {f_ack, m_stb}); end
        ena = 1'b1; f_stb = 1'b0; f_wre = 1'b0;
        cyc();
        ena = 1'b0;
        vectors++; if (f_ack !== 1'b0) begin errors++; $display("FAIL lat_ena_clear got %b want 0", f_ack); end
        vectors++; if (mem[8'h10] !== 16'hBEEF) begin errors++; $display("FAIL lat_mem_write got %h want beef", mem[8'h10]); end
    endtask

    task automatic test_fg_order();
        bit seen_f = 0;
        bit done = 0;
        wait_states = 0;
        mem[8'h20] = 16'h1111; mem[8'h30] = 16'h2222;
        f_adr = 16'h0020; f_wre = 1'b0; g_adr = 16'h0030; g_wre = 1'b0;
        f_stb = 1'b1; g_stb = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (f_ack && !seen_f) begin
                seen_f = 1;
                vectors++; if (g_ack !== 1'b0) begin errors++; $display("FAIL fg_f_first got g_ack=%b want 0", g_ack); end
                vectors++; if (f_dti !== 16'h1111) begin errors++; $display("FAIL fg_f_live got %h want 1111", f_dti); end
            end
            if (f_ack && g_ack) done = 1;
        end
        vectors++; if (!done) begin errors++; $display("FAIL fg_timeout got acks=%b want 11", {f_ack, g_ack}); end
        vectors++; if (f_dti !== 16'h1111) begin errors++; $display("FAIL fg_f_held got %h want 1111", f_dti); end
        vectors++; if (g_dti !== 16'h2222) begin errors++; $display("FAIL fg_g_dti got %h want 2222", g_dti); end
        cyc();
        vectors++; if ({f_ack, g_ack, m_stb} !== 3'b110) begin errors++; $display("FAIL fg_hold got ack_f,ack_g,stb=%b want 110", {f_ack, g_ack, m_stb}); end
        vectors++; if (g_dti !== 16'h2222) begin errors++; $display("FAIL fg_g_held got %h want 2222", g_dti); end
        ena = 1'b1;
        cyc();
        vectors++; if ({f_ack, g_ack} !== 2'b00) begin errors++; $display("FAIL fg_ena_drop got %b want 00", {f_ack, g_ack}); end
        ena = 1'b0; f_stb = 1'b0; g_stb = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midbusy();
        wait_states = 3;
        f_adr = 16'h0040; f_wre = 1'b0; f_stb = 1'b1;
        cyc();
        vectors++; if (m_stb !== 1'b1) begin errors++; $display("FAIL rmb_busy got %b want 1", m_stb); end
        cyc();
        vectors++; if (f_ack !== 1'b0) begin errors++; $display("FAIL rmb_early_ack got %b want 0", f_ack); end
        rst = 1'b1; f_stb = 1'b0;
        #1;
        vectors++; if ({m_stb, gnt} !== 3'b000) begin errors++; $display("FAIL rmb_async got stb,gnt=%b want 000", {m_stb, gnt}); end
        vectors++; if (f_dti !== 16'h0000) begin errors++; $display("FAIL rmb_held_clear got %h want 0000", f_dti); end
        cyc();
        rst = 1'b0;
        cyc();
        ack_force = 1'b1; f_stb = 1'b1;
        #1;
        vectors++; if ({f_ack, g_ack, x_ack} !== 3'b000) begin errors++; $display("FAIL rmb_late_ack got %b want 000", {f_ack, g_ack, x_ack}); end
        cyc();
        ack_force = 1'b0; f_stb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            vectors++; if ({f_ack, g_ack, x_ack} !== 3'b000) begin errors++; $display("FAIL rmb_no_ack got %b want 000", {f_ack, g_ack, x_ack}); end
        end
        vectors++; if (m_stb !== 1'b0) begin errors++; $display("FAIL rmb_settle got %b want 0", m_stb); end
    endtask

    task automatic test_drop_g();
        bit got = 0;
        wait_states = 2;
        g_adr = 16'h0050; g_wre = 1'b0; g_stb = 1'b1;
        cyc();
        cyc();
        g_stb = 1'b0;
        cyc();
        vectors++; if ({m_ack, g_ack} !== 2'b10) begin errors++; $display("FAIL dropg_mask got mack,gack=%b want 10", {m_ack, g_ack}); end
        cyc();
        vectors++; if ({m_stb, g_ack} !== 2'b00) begin errors++; $display("FAIL dropg_idle got stb,gack=%b want 00", {m_stb, g_ack}); end
        g_stb = 1'b1;
        cyc();
        vectors++; if ({m_stb, gnt} !== 3'b110) begin errors++; $display("FAIL dropg_regrant got stb,gnt=%b want 110", {m_stb, gnt}); end
        for (int i = 0; i < 10 && !got; i++) begin
            if (g_ack) got = 1; else cyc();
        end
        vectors++; if (!got) begin errors++; $display("FAIL dropg_timeout got g_ack=%b want 1", g_ack); end
        vectors++; if (g_dti !== init_val(8'h50)) begin errors++; $display("FAIL dropg_data got %h want %h", g_dti, init_val(8'h50)); end
        ena = 1'b1; g_stb = 1'b0;
        cyc();
        ena = 1'b0;
    endtask

`ifdef DCPU16_MARB_XPORT_EN
    task automatic test_starvation();
        int rounds = 0;
        int n_fg = 0;
        logic [1:0] prev = 2'd0;
        wait_states = 0;
        f_adr = 16'h0020; f_wre = 1'b0; g_adr = 16'h0030; g_wre = 1'b0;
        x_adr = 16'h0070; x_wre = 1'b0; x_dto = 16'h0000;
        f_stb = 1'b1; g_stb = 1'b1; x_stb = 1'b1;
        for (int i = 0; i < 200 && rounds < 2; i++) begin
            cyc();
            if (gnt != 2'd0 && prev == 2'd0) begin
                if (gnt == 2'd3) begin
                    vectors++; if (n_fg != 4) begin errors++; $display("FAIL starve_count round %0d got %0d want 4", rounds, n_fg); end
                    vectors++; if ({x_ack, x_dti} !== {1'b1, init_val(8'h70)}) begin errors++; $display("FAIL starve_x_data got %b/%h want 1/%h", x_ack, x_dti, init_val(8'h70)); end
                    rounds++;
                    n_fg = 0;
                end else begin
                    n_fg++;
                end
            end
            prev = gnt;
            ena = f_ack & g_ack;
        end
        vectors++; if (rounds != 2) begin errors++; $display("FAIL starve_timeout got %0d x grants want 2", rounds); end
        x_stb = 1'b0; f_stb = 1'b0; g_stb = 1'b0; ena = 1'b1;
        cyc();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
    endtask
`else
    task automatic test_no_xport();
        x_adr = 16'h0060; x_dto = 16'h1234; x_wre = 1'b1; x_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++; if ({m_stb, x_ack} !== 2'b00) begin errors++; $display("FAIL nox_idle got stb,xack=%b want 00", {m_stb, x_ack}); end
            vectors++; if (gnt === 2'd3) begin errors++; $display("FAIL nox_gnt got %0d want not 3", gnt); end
            vectors++; if (x_dti !== 16'h0000) begin errors++; $display("FAIL nox_dti got %h want 0000", x_dti); end
        end
        x_stb = 1'b0; x_wre = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int b = 0; b < 30; b++) begin
            bit do_f, do_g, seen_f, seen_g, g_first, ok;
            logic [7:0] fa, ga;
            logic [15:0] fd, exp_f, exp_g;
            wait_states = $urandom_range(0, 3);
            do_f = 1'($urandom_range(0, 1));
            do_g = 1'($urandom_range(0, 1));
            if (!do_f && !do_g) do_f = 1;
            fa = 8'h80 + 8'($urandom_range(0, 15));
            ga = 8'h80 + 8'($urandom_range(0, 15));
            fd = 16'($urandom);
            f_wre = 1'($urandom_range(0, 1));
            exp_f = 16'h0; exp_g = 16'h0;
            // Reference order: F before G within one pipeline step
            if (do_f) begin
                if (f_wre) ref_mem[fa] = fd; else exp_f = ref_mem[fa];
            end
            if (do_g) exp_g = ref_mem[ga];
            f_adr = {8'h00, fa}; f_dto = fd; g_adr = {8'h00, ga}; g_wre = 1'b0;
            f_stb = do_f; g_stb = do_g;
            seen_f = 0; seen_g = 0; g_first = 0; ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                cyc();
                if (f_ack) seen_f = 1;
                if (g_ack && !seen_g) begin
                    seen_g = 1;
                    if (do_f && !seen_f) g_first = 1;
                end
                ok = (!do_f || f_ack) && (!do_g || g_ack);
            end
            vectors++; if (!ok) begin errors++; $display("FAIL rnd_timeout batch %0d got acks=%b want %b", b, {f_ack, g_ack}, {do_f, do_g}); end
            vectors++; if (g_first) begin errors++; $display("FAIL rnd_order batch %0d got G before F want F first", b); end
            if (do_f && !f_wre) begin
                vectors++; if (f_dti !== exp_f) begin errors++; $display("FAIL rnd_f_dti batch %0d got %h want %h", b, f_dti, exp_f); end
            end
            if (do_g) begin
                vectors++; if (g_dti !== exp_g) begin errors++; $display("FAIL rnd_g_dti batch %0d got %h want %h", b, g_dti, exp_g); end
            end
            ena = 1'b1; f_stb = 1'b0; g_stb = 1'b0;
            cyc();
            ena = 1'b0;
            vectors++; if ({f_ack, g_ack} !== 2'b00) begin errors++; $display("FAIL rnd_release batch %0d got %b want 00", b, {f_ack, g_ack}); end
        end
        for (int a = 8'h80; a < 8'h90; a++) begin
            vectors++; if (mem[a] !== ref_mem[a]) begin errors++; $display("FAIL rnd_mem addr %h got %h want %h", a, mem[a], ref_mem[a]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        ack_q = 1'b0; ack_force = 1'b0; wcnt = 0; wait_states = 0; rdata = 16'h0;
        rst = 1'b1; ena = 1'b0;
        f_adr = 16'h0; f_dto = 16'h0; f_stb = 1'b0; f_wre = 1'b0;
        g_adr = 16'h0; g_stb = 1'b0; g_wre = 1'b0;
        x_adr = 16'h0; x_dto = 16'h0; x_stb = 1'b0; x_wre = 1'b0;
        test_reset();
        test_write_latency();
        test_fg_order();
        test_reset_midbusy();
        test_drop_g();
`ifdef DCPU16_MARB_XPORT_EN
        test_starvation();
`else
        test_no_xport();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcpu16_marb.md
# dcpu16_marb

Single-port memory arbiter for the DCPU16 core. It merges the CPU's F-bus (read/write) and G-bus (read) with an optional external X-bus (DMA or device master) onto one simplified-Wishbone memory port. It holds each CPU-side acknowledge and its read data until the CPU pipeline advances, so the core's stall equation (stb XNOR ack on both buses) stays consistent when the two buses complete in different cycles.

## Interface
Parameters:
- XWAIT, default 4: consecutive F/G grants tolerated while X is pending before X is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ena  in  1  CPU pipeline advance; clears the held F/G completions.
- f_adr, f_dto  in  16 each  F-bus address and write data.
- f_stb, f_wre  in  1 each  F-bus strobe and write enable.
- f_dti  out  16  F-bus read data.
- f_ack  out  1  F-bus acknowledge.
- g_adr  in  16  G-bus address.
- g_stb, g_wre  in  1 each  G-bus strobe and write enable.
- g_dti  out  16  G-bus read data.
- g_ack  out  1  G-bus acknowledge.
- x_adr, x_dto  in  16 each  X-bus address and write data.
- x_stb, x_wre  in  1 each  X-bus strobe and write enable.
- x_dti  out  16  X-bus read data.
- x_ack  out  1  X-bus acknowledge.
- m_adr, m_dto  out  16 each  memory address and write data.
- m_stb, m_wre  out  1 each  memory strobe and write enable.
- m_dti  in  16  memory read data.
- m_ack  in  1  memory acknowledge; one-cycle pulse.
- gnt  out  2  current owner: 0 none, 1 F, 2 G, 3 X.

## Operation
- FSM has two states, IDLE and BUSY. Reset enters IDLE.
- Eligible requester: stb high and done flag clear. Only F and G have done flags.
- Arbitration occurs in IDLE only. Fixed priority is F > G > X.
- Starvation override: if xcnt == XWAIT and x_stb is high, X wins.
- IDLE → BUSY when any requester is eligible. On that edge the arbiter registers gnt and the winner's adr, wre and dto into m_adr, m_wre and m_dto, and sets m_stb = 1.
- In BUSY, m_* outputs hold constant until m_ack.
- BUSY → IDLE on m_ack. m_stb drops on the same edge.
- Live completion: gnt matches the port and m_ack is high.
- F/G completion on m_ack:
  - Set the port's done flag.
  - Load the port's held data register with m_dti. Load it on writes too.
- Done flag clears when ena = 1 or the port's stb = 0. Clear has priority over set only when the set and clear are for different transactions; a set on the same edge as ena is discarded.
- f_ack = f_stb & (done_f | live_f). g_ack is formed the same way.
- f_dti = live_f ? m_dti : held_f. g_dti is formed the same way.
- x_ack = live_x. x_dti = m_dti when live_x, else 0.
- xcnt (4 bits):
  - Increments when F or G is granted while x_stb is high.
  - Resets to 0 when X is granted or when x_stb is low.
  - Saturates at XWAIT.
- A requester that drops stb mid-transaction does not abort the transaction. The memory cycle completes, and its ack is masked by the stb term.

## Timing
- Reset values: m_stb, m_wre and gnt are 0; m_adr, m_dto, held_f and held_g are 0; all done flags are 0; xcnt is 0. f_ack, g_ack and x_ack are therefore 0.
- Async reset mid-BUSY drops m_stb immediately. A later m_ack is ignored in IDLE.
- Latency: request at cycle t, m_stb at t+1. With a zero-wait memory, ack at t+1.
- Minimum spacing between transactions is 2 cycles, because there is one IDLE arbitration cycle between them.
- Combinational paths: m_ack → *_ack and m_dti → *_dti.
- Simultaneous F and G requests in IDLE: F is served first, then G. The first completion holds f_ack high until ena.
- m_ack received in IDLE is ignored.

## Configuration
- DCPU16_MARB_XPORT_EN defined: X port, xcnt and the starvation override are present as described above.
- DCPU16_MARB_XPORT_EN undefined:
  - x_stb, x_adr, x_dto and x_wre are ignored.
  - x_ack = 0 and x_dti = 0.
  - gnt never equals 3.
  - Arbitration is F > G only, and xcnt is absent.

## Test plan
- Zero-wait memory with m_ack = m_stb; f_stb=1, f_wre=1, f_adr=0x0010, f_dto=0xBEEF → m_stb at t+1 with m_adr=0x0010, m_wre=1, m_dto=0xBEEF; f_ack=1 at t+1.
- f_stb and g_stb both high, memory returns 0x1111 then 0x2222, ena held 0 → F served first; f_ack stays 1 with f_dti=0x1111 while G is served; g_ack rises with g_dti=0x2222; one ena pulse drops both acks.
- x_stb held high, F and G re-requesting after every ena, XWAIT=4 → X granted after exactly 4 F/G grants; xcnt returns to 0.
- Memory with 3 wait states; rst asserted in the second BUSY cycle → m_stb=0 immediately; late m_ack ignored; no ack pulse on any port.
- g_stb dropped in the cycle before m_ack → transaction completes, g_ack stays 0, done_g stays clear, FSM returns to IDLE.
- Build without DCPU16_MARB_XPORT_EN, x_stb=1 → m_stb never asserts for X; x_ack=0; gnt never equals 3.
